lsu_mem_master: RTL and testbench

//  Initiator side of the core data-memory port. Accepts one load/store at a time from
//  the execute stage, drives the word-aligned byte-masked memory port (valid, write

---
 rtl/lsu_mem_master.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Data-memory initiator: one load/store in flight, word-aligned byte-masked memory port,
// sign/zero-extended load return; misaligned or illegal ops are answered without a memory access.
module lsu_mem_master #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | ready for a new op (once out of reset)
  // ACCESS | memory request held for MEM_WAIT cycles, wait counter counts down
  // RESP   | response presented until the consumer takes it
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_WAIT - 1);

  logic [1:0]    state;
  logic          armed;
  logic [CW-1:0] cnt;

  logic          op_write;
  logic [2:0]    op_f3;
  logic [1:0]    op_off;
  logic [29:0]   op_word;
  logic [31:0]   op_wdata;
  logic [3:0]    op_mask;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          req_err;
  logic [1:0]    req_off;
  logic [3:0]    req_mask;
  logic          access;
  logic          last;
  logic [31:0]   sh;
  logic [31:0]   ext;

  // armed keeps req_ready low while reset is asserted and for the first edge after release
  assign req_ready = armed && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_off   = req_addr[1:0];
  assign access    = (state == ACCESS);
  assign last      = (cnt == '0);

  always_comb begin
    req_err = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
      req_err = 1'b1;
    if (req_write && req_funct3[2])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_off[0])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_off != 2'b00)
      req_err = 1'b1;
  end

  always_comb begin
    req_mask = 4'b0000;
    case (req_funct3[1:0])
      2'b00:   req_mask = 4'b0001 << req_off;
      2'b01:   req_mask = 4'b0011 << req_off;
      2'b10:   req_mask = 4'b1111;
      default: req_mask = 4'b0000;
    endcase
  end

  always_comb begin
    sh  = mem_rdata >> {op_off, 3'b000};
    ext = 32'h0;
    case (op_f3)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ext = {24'h0, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ext = {16'h0, sh[15:0]};
      3'b010:  ext = sh;
      default: ext = 32'h0;
    endcase
    if (op_write)
      ext = 32'h0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      cnt      <= '0;
      op_write <= 1'b0;
      op_f3    <= 3'b000;
      op_off   <= 2'b00;
      op_word  <= 30'h0;
      op_wdata <= 32'h0;
      op_mask  <= 4'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            op_write <= req_write;
            op_f3    <= req_funct3;
            op_off   <= req_off;
            op_word  <= req_addr[31:2];
            op_wdata <= req_wdata << {req_off, 3'b000};
            op_mask  <= req_mask;
            rdata_q  <= 32'h0;
            err_q    <= req_err;
            cnt      <= CNT_LOAD;
            state    <= req_err ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (last) begin
            rdata_q <= ext;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid       = (state == RESP);
  assign resp_rdata       = resp_valid ? rdata_q : 32'h0;
  assign resp_err         = resp_valid && err_q;
  assign mem_valid        = access;
  assign mem_write_enable = access && op_write && last;
  assign mem_addr         = access ? {op_word, 2'b00} : 32'h0;
  assign mem_wdata        = (access && op_write) ? op_wdata : 32'h0;
  assign mem_wmask        = access ? op_mask : 4'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: a MEM_WAIT=1 instance driven from a vector table and a
// MEM_WAIT=3 instance for back-pressure and mid-access reset sequences.
module tb_lsu_mem_master;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic        rst1_n, req_valid_1, req_ready_1, req_write_1, resp_valid_1, resp_ready_1, resp_err_1;
  logic [2:0]  req_funct3_1;
  logic [31:0] req_addr_1, req_wdata_1, resp_rdata_1;
  logic        mem_valid_1, mem_write_enable_1;
  logic [31:0] mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic [3:0]  mem_wmask_1;

  logic        rst3_n, req_valid_3, req_ready_3, req_write_3, resp_valid_3, resp_ready_3, resp_err_3;
  logic [2:0]  req_funct3_3;
  logic [31:0] req_addr_3, req_wdata_3, resp_rdata_3;
  logic        mem_valid_3, mem_write_enable_3;
  logic [31:0] mem_addr_3, mem_wdata_3, mem_rdata_3;
  logic [3:0]  mem_wmask_3;

  lsu_mem_master #(.MEM_WAIT(1)) u1 (
    .clock(clock), .reset(rst1_n),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
    .req_funct3(req_funct3_1), .req_addr(req_addr_1), .req_wdata(req_wdata_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1), .resp_rdata(resp_rdata_1),
    .resp_err(resp_err_1), .mem_valid(mem_valid_1), .mem_write_enable(mem_write_enable_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_wmask(mem_wmask_1),
    .mem_rdata(mem_rdata_1)
  );

  lsu_mem_master #(.MEM_WAIT(3)) u3 (
    .clock(clock), .reset(rst3_n),
    .req_valid(req_valid_3), .req_ready(req_ready_3), .req_write(req_write_3),
    .req_funct3(req_funct3_3), .req_addr(req_addr_3), .req_wdata(req_wdata_3),
    .resp_valid(resp_valid_3), .resp_ready(resp_ready_3), .resp_rdata(resp_rdata_3),
    .resp_err(resp_err_3), .mem_valid(mem_valid_3), .mem_write_enable(mem_write_enable_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_wmask(mem_wmask_3),
    .mem_rdata(mem_rdata_3)
  );

  // memory models: 16 words at 0x80000000, read data masked to the requested lanes
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  int wcnt1 = 0;
  int wcnt3 = 0;

  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  assign mem_rdata_1 = mem_valid_1 ? (mem1[mem_addr_1[5:2]] & lanes(mem_wmask_1)) : 32'h0;
  assign mem_rdata_3 = mem_valid_3 ? (mem3[mem_addr_3[5:2]] & lanes(mem_wmask_3)) : 32'h0;

  always @(posedge clock) begin
    if (mem_valid_1 && mem_write_enable_1) begin
      mem1[mem_addr_1[5:2]] <= (mem1[mem_addr_1[5:2]] & ~lanes(mem_wmask_1)) | (mem_wdata_1 & lanes(mem_wmask_1));
      wcnt1 <= wcnt1 + 1;
    end
    if (mem_valid_3 && mem_write_enable_3) begin
      mem3[mem_addr_3[5:2]] <= (mem3[mem_addr_3[5:2]] & ~lanes(mem_wmask_3)) | (mem_wdata_3 & lanes(mem_wmask_3));
      wcnt3 <= wcnt3 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  mask;
    logic [31:0] mwdata;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic run1(input vec_t v, input int idx);
    int lat, mv, wec;
    logic [3:0] m;
    logic [31:0] a, wd;
    bit got;
    lat = 0; mv = 0; wec = 0; got = 0; m = 4'h0; a = 32'h0; wd = 32'h0;
    @(negedge clock);
    for (int i = 0; i < 10 && !req_ready_1; i++) @(negedge clock);
    chk($sformatf("v%0d_ready", idx), {31'h0, req_ready_1}, 32'h1);
    req_write_1 = v.write; req_funct3_1 = v.f3; req_addr_1 = v.addr; req_wdata_1 = v.wdata;
    req_valid_1 = 1'b1;
    @(posedge clock);
    #1 req_valid_1 = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clock);
      if (mem_valid_1) begin
        mv++; m = mem_wmask_1; a = mem_addr_1; wd = mem_wdata_1;
      end
      if (mem_write_enable_1) wec++;
      if (resp_valid_1) begin
        got = 1; lat = c;
        chk($sformatf("v%0d_rdata", idx), resp_rdata_1, v.rdata);
        chk($sformatf("v%0d_err", idx), {31'h0, resp_err_1}, {31'h0, v.err});
      end
    end
    chk($sformatf("v%0d_resp_seen", idx), {31'h0, got}, 32'h1);
    chk($sformatf("v%0d_latency", idx), lat, v.err ? 1 : 2);
    chk($sformatf("v%0d_mem_cycles", idx), mv, v.err ? 0 : 1);
    chk($sformatf("v%0d_strobes", idx), wec, (v.write && !v.err) ? 1 : 0);
    if (!v.err) begin
      chk($sformatf("v%0d_mask", idx), {28'h0, m}, {28'h0, v.mask});
      chk($sformatf("v%0d_addr", idx), a, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_wdata", idx), wd, v.write ? v.mwdata : 32'h0);
    end
  endtask

  // issues one op on the MEM_WAIT=3 instance and watches until resp_valid appears
  task automatic op3(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                     output int mv, output int wec, output int weidx, output int lat,
                     output bit rdy_low, output bit addr_stable, output logic [31:0] rdata);
    logic [31:0] a0;
    bit got;
    mv = 0; wec = 0; weidx = 0; lat = 0; rdy_low = 1; addr_stable = 1; rdata = 32'h0; got = 0; a0 = 32'h0;
    @(negedge clock);
    for (int i = 0; i < 10 && !req_ready_3; i++) @(negedge clock);
    chk("u3_ready_before_op", {31'h0, req_ready_3}, 32'h1);
    req_write_3 = wr; req_funct3_3 = f3; req_addr_3 = addr; req_wdata_3 = wdata;
    req_valid_3 = 1'b1;
    @(posedge clock);
    #1 req_valid_3 = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clock);
      if (req_ready_3) rdy_low = 0;
      if (mem_valid_3) begin
        if (mv == 0) a0 = mem_addr_3;
        else if (mem_addr_3 !== a0) addr_stable = 0;
        mv++;
      end
      if (mem_write_enable_3) begin
        wec++; weidx = c;
      end
      if (resp_valid_3) begin
        got = 1; lat = c; rdata = resp_rdata_3;
      end
    end
  endtask

  initial begin
    int mv, wec, weidx, lat, w0;
    bit rdy_low, astab, hold_ok;
    logic [31:0] rd;

    for (int i = 0; i < 16; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    mem1[0] = 32'h8899AABB;

    vt[0]  = '{1'b0, 3'b000, 32'h80000003, 32'h0,        32'hFFFFFF88, 1'b0, 4'h8, 32'h0};
    vt[1]  = '{1'b0, 3'b101, 32'h80000002, 32'h0,        32'h00008899, 1'b0, 4'hC, 32'h0};
    vt[2]  = '{1'b0, 3'b010, 32'h80000000, 32'h0,        32'h8899AABB, 1'b0, 4'hF, 32'h0};
    vt[3]  = '{1'b0, 3'b100, 32'h80000001, 32'h0,        32'h000000AA, 1'b0, 4'h2, 32'h0};
    vt[4]  = '{1'b0, 3'b001, 32'h80000000, 32'h0,        32'hFFFFAABB, 1'b0, 4'h3, 32'h0};
    vt[5]  = '{1'b1, 3'b000, 32'h80000001, 32'hDEADBEEF, 32'h0,        1'b0, 4'h2, 32'hADBEEF00};
    vt[6]  = '{1'b0, 3'b010, 32'h80000000, 32'h0,        32'h8899EFBB, 1'b0, 4'hF, 32'h0};
    vt[7]  = '{1'b1, 3'b001, 32'h80000006, 32'h12345678, 32'h0,        1'b0, 4'hC, 32'h56780000};
    vt[8]  = '{1'b0, 3'b101, 32'h80000006, 32'h0,        32'h00005678, 1'b0, 4'hC, 32'h0};
    vt[9]  = '{1'b1, 3'b010, 32'h80000008, 32'hCAFEF00D, 32'h0,        1'b0, 4'hF, 32'hCAFEF00D};
    vt[10] = '{1'b0, 3'b000, 32'h80000008, 32'h0,        32'h0000000D, 1'b0, 4'h1, 32'h0};
    vt[11] = '{1'b0, 3'b000, 32'h8000000B, 32'h0,        32'hFFFFFFCA, 1'b0, 4'h8, 32'h0};
    vt[12] = '{1'b0, 3'b010, 32'h80000002, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
    vt[13] = '{1'b1, 3'b001, 32'h80000001, 32'h11111111, 32'h0,        1'b1, 4'h0, 32'h0};
    vt[14] = '{1'b0, 3'b011, 32'h80000000, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
    vt[15] = '{1'b0, 3'b110, 32'h80000000, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
    vt[16] = '{1'b0, 3'b111, 32'h80000000, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
    vt[17] = '{1'b1, 3'b100, 32'h80000000, 32'h22222222, 32'h0,        1'b1, 4'h0, 32'h0};
    vt[18] = '{1'b0, 3'b001, 32'h80000003, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
    vt[19] = '{1'b0, 3'b101, 32'h80000001, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};

    rst1_n = 1'b0; rst3_n = 1'b0;
    req_valid_1 = 1'b0; req_write_1 = 1'b0; req_funct3_1 = 3'b0; req_addr_1 = 32'h0; req_wdata_1 = 32'h0;
    req_valid_3 = 1'b0; req_write_3 = 1'b0; req_funct3_3 = 3'b0; req_addr_3 = 32'h0; req_wdata_3 = 32'h0;
    resp_ready_1 = 1'b1; resp_ready_3 = 1'b1;

    repeat (3) @(negedge clock);
    chk("rst_req_ready", {31'h0, req_ready_1}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid_1}, 32'h0);
    chk("rst_resp_rdata", resp_rdata_1, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err_1}, 32'h0);
    chk("rst_mem_valid", {31'h0, mem_valid_1}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_write_enable_1}, 32'h0);
    chk("rst_mem_addr", mem_addr_1, 32'h0);
    chk("rst_mem_wdata", mem_wdata_1, 32'h0);
    chk("rst_mem_wmask", {28'h0, mem_wmask_1}, 32'h0);
    chk("rst_u3_req_ready", {31'h0, req_ready_3}, 32'h0);
    rst1_n = 1'b1; rst3_n = 1'b1;

    for (int i = 0; i < NV; i++) run1(vt[i], i);
    chk("u1_total_writes", wcnt1, 3);

    // back-pressure: MEM_WAIT=3 store held in RESP for 4 cycles
    resp_ready_3 = 1'b0;
    op3(1'b1, 3'b010, 32'h80000004, 32'h11223344, mv, wec, weidx, lat, rdy_low, astab, rd);
    chk("bp_sw_mem_cycles", mv, 3);
    chk("bp_sw_strobes", wec, 1);
    chk("bp_sw_strobe_cycle", weidx, 3);
    chk("bp_sw_latency", lat, 4);
    chk("bp_sw_addr_stable", {31'h0, astab}, 32'h1);
    chk("bp_sw_ready_low", {31'h0, rdy_low}, 32'h1);
    hold_ok = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (!resp_valid_3 || resp_rdata_3 !== 32'h0 || resp_err_3 || req_ready_3 || mem_valid_3) hold_ok = 0;
    end
    chk("bp_sw_hold", {31'h0, hold_ok}, 32'h1);
    resp_ready_3 = 1'b1;
    @(negedge clock);
    chk("bp_sw_released", {31'h0, resp_valid_3}, 32'h0);
    chk("bp_sw_mem", mem3[1], 32'h11223344);

    resp_ready_3 = 1'b0;
    op3(1'b0, 3'b010, 32'h80000004, 32'h0, mv, wec, weidx, lat, rdy_low, astab, rd);
    chk("bp_lw_rdata", rd, 32'h11223344);
    chk("bp_lw_mem_cycles", mv, 3);
    chk("bp_lw_strobes", wec, 0);
    hold_ok = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      if (!resp_valid_3 || resp_rdata_3 !== 32'h11223344 || req_ready_3) hold_ok = 0;
    end
    chk("bp_lw_hold", {31'h0, hold_ok}, 32'h1);
    resp_ready_3 = 1'b1;

    // reset asserted in the second ACCESS cycle of a store
    @(negedge clock);
    for (int i = 0; i < 10 && !req_ready_3; i++) @(negedge clock);
    w0 = wcnt3;
    req_write_3 = 1'b1; req_funct3_3 = 3'b010; req_addr_3 = 32'h8000000C; req_wdata_3 = 32'h55555555;
    req_valid_3 = 1'b1;
    @(posedge clock);
    #1 req_valid_3 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rstmid_mem_valid_before", {31'h0, mem_valid_3}, 32'h1);
    rst3_n = 1'b0;
    #1;
    chk("rstmid_mem_valid", {31'h0, mem_valid_3}, 32'h0);
    chk("rstmid_mem_we", {31'h0, mem_write_enable_3}, 32'h0);
    repeat (2) @(negedge clock);
    chk("rstmid_resp_valid", {31'h0, resp_valid_3}, 32'h0);
    chk("rstmid_req_ready", {31'h0, req_ready_3}, 32'h0);
    rst3_n = 1'b1;
    @(negedge clock);
    chk("rstmid_ready_after", {31'h0, req_ready_3}, 32'h1);
    chk("rstmid_no_write", wcnt3 - w0, 0);
    chk("rstmid_mem", mem3[3], 32'h0);
    op3(1'b0, 3'b010, 32'h8000000C, 32'h0, mv, wec, weidx, lat, rdy_low, astab, rd);
    chk("rstmid_lw_latency", lat, 4);
    chk("rstmid_lw_rdata", rd, 32'h0);
    chk("rstmid_lw_err", {31'h0, resp_err_3}, 32'h0);
    chk("rstmid_lw_mem_cycles", mv, 3);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
